// File: rtl/cascade_dpa_scheduler.sv
// Round-robin sequencer granting one lane at a time to the bit-align engines, with timeout/retry supervision.
// Optional timeout statistics counter enabled by defining CASCADE_DPA_STAT_EN.
module cascade_dpa_scheduler #(
  parameter int unsigned LANE_NUM    = 10,
  parameter int unsigned LANE_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned GAP_CYC     = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_abort,
  input  logic [LANE_NUM-1:0] i_dpa_dval,
  input  logic [LANE_NUM-1:0] i_bitalign_done,
  output logic [LANE_NUM-1:0] o_dpa_req,
  output logic [LANE_NUM-1:0] o_dpa_done,
  output logic [LANE_NUM-1:0] o_lane_fail,
  output logic                o_busy,
  output logic [LANE_W-1:0]   o_cur_lane,
  output logic [7:0]          o_timeout_cnt
);

  localparam int unsigned TMR_W = 16;
  localparam int unsigned RTY_W = 4;
  localparam int unsigned GAP_W = 8;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_REQ,
    S_WAIT,
    S_GAP
  } state_t;

  state_t             state;
  logic [LANE_W-1:0]  rr;
  logic [TMR_W-1:0]   timer;
  logic [RTY_W-1:0]   retry;
  logic [GAP_W-1:0]   gap_cnt;
  logic               gap_to_req;

  logic [LANE_NUM-1:0] pending;
  logic [LANE_NUM-1:0] cur_mask;
  logic                cur_dval;
  logic                cur_bdone;
  logic                timeout_evt;

  logic [LANE_NUM-1:0] pending_sh;
  int unsigned         arb_idx;
  logic                arb_found;
  logic [LANE_W-1:0]   arb_lane;

  assign pending     = i_dpa_dval & ~o_dpa_done & ~o_lane_fail;
  assign cur_mask    = LANE_NUM'(1) << o_cur_lane;
  assign cur_dval    = |(i_dpa_dval & cur_mask);
  assign cur_bdone   = |(i_bitalign_done & cur_mask);
  // Done on the final timer cycle beats the timeout.
  assign timeout_evt = (state == S_WAIT) && cur_dval && !cur_bdone && (timer == TMR_LAST);

  // First pending lane strictly after rr, wrapping; lowest offset wins.
  always_comb begin
    arb_found  = 1'b0;
    arb_lane   = '0;
    arb_idx    = 0;
    pending_sh = '0;
    for (int unsigned i = LANE_NUM; i >= 1; i--) begin
      arb_idx    = (32'(rr) + i) % LANE_NUM;
      pending_sh = pending >> arb_idx;
      if (pending_sh[0]) begin
        arb_found = 1'b1;
        arb_lane  = LANE_W'(arb_idx);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      rr          <= LANE_W'(LANE_NUM - 1);
      timer       <= '0;
      retry       <= '0;
      gap_cnt     <= '0;
      gap_to_req  <= 1'b0;
      o_dpa_req   <= '0;
      o_dpa_done  <= '0;
      o_lane_fail <= '0;
      o_busy      <= 1'b0;
      o_cur_lane  <= '0;
    end else if (i_abort) begin
      state       <= S_IDLE;
      timer       <= '0;
      retry       <= '0;
      gap_cnt     <= '0;
      gap_to_req  <= 1'b0;
      o_dpa_req   <= '0;
      o_dpa_done  <= '0;
      o_lane_fail <= '0;
      o_busy      <= 1'b0;
    end else begin
      // Withdrawn requests drop their sticky status.
      o_dpa_done  <= o_dpa_done & i_dpa_dval;
      o_lane_fail <= o_lane_fail & i_dpa_dval;
      case (state)
        S_IDLE: begin
          if (|pending) begin
            state  <= S_ARB;
            o_busy <= 1'b1;
          end
        end
        S_ARB: begin
          if (arb_found) begin
            o_cur_lane <= arb_lane;
            rr         <= arb_lane;
            retry      <= '0;
            state      <= S_REQ;
          end else begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end
        S_REQ: begin
          if (!cur_dval) begin
            state      <= S_GAP;
            gap_cnt    <= '0;
            gap_to_req <= 1'b0;
          end else begin
            o_dpa_req <= cur_mask;
            timer     <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          timer <= timer + TMR_W'(1);
          if (!cur_dval) begin
            o_dpa_req  <= '0;
            state      <= S_GAP;
            gap_cnt    <= '0;
            gap_to_req <= 1'b0;
          end else if (cur_bdone) begin
            o_dpa_req  <= '0;
            o_dpa_done <= (o_dpa_done & i_dpa_dval) | cur_mask;
            state      <= S_GAP;
            gap_cnt    <= '0;
            gap_to_req <= 1'b0;
          end else if (timeout_evt) begin
            o_dpa_req <= '0;
            retry     <= retry + RTY_W'(1);
            state     <= S_GAP;
            gap_cnt   <= '0;
            if ((retry + RTY_W'(1)) == RTY_MAX) begin
              o_lane_fail <= (o_lane_fail & i_dpa_dval) | cur_mask;
              gap_to_req  <= 1'b0;
            end else begin
              gap_to_req  <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (gap_to_req && cur_dval) begin
              state <= S_REQ;
            end else begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef CASCADE_DPA_STAT_EN
  logic [7:0] tcnt;

  // Saturating count of attempt timeouts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tcnt <= 8'd0;
    end else if (i_abort) begin
      tcnt <= 8'd0;
    end else if (timeout_evt && (tcnt != 8'hFF)) begin
      tcnt <= tcnt + 8'd1;
    end
  end

  assign o_timeout_cnt = tcnt;
`else
  assign o_timeout_cnt = 8'd0;
`endif

endmodule
